// File: rtl/rx_chan_fifo_bank.sv
// Receive FIFO bank on rxclk: FIFO 0 buffers control words, FIFO k+1 buffers
// interleaved I/Q words of data channel k; one muxed show-ahead read port.
module rx_chan_fifo_bank #(
    parameter int NUM_CHAN   = 2,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                    rxclk,
    input  logic                    reset,
    input  logic [3:0]              channels,
    input  logic                    rxstrobe,
    input  logic [32*NUM_CHAN-1:0]  rx_data,
    input  logic                    ctrl_wr,
    input  logic [15:0]             ctrl_data,
    input  logic [NUM_CHAN:0]       flush,
    input  logic [NUM_CHAN:0]       overrun_clr,
    input  logic [3:0]              rd_select,
    input  logic                    chan_rdreq,
    output logic [15:0]             chan_fifodata,
    output logic [NUM_CHAN:0]       chan_empty,
    output logic [9:0]              chan_usedw,
    output logic [NUM_CHAN:0]       overrun
);

    localparam int unsigned NF = NUM_CHAN + 1;
    localparam logic [DEPTH_LOG2-1:0] CNT_FULL     = '1;
    localparam logic [DEPTH_LOG2-1:0] CNT_PAIR_MAX = {{(DEPTH_LOG2-2){1'b1}}, 2'b01};

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_WR_Q = 1'b1;

    logic [15:0]           mem_q [NF][2**DEPTH_LOG2];

    logic [0:0]            state_q, state_d;
    logic [NUM_CHAN-1:0]   mask_q, mask_d;
    logic [15:0]           q_lat_q [NUM_CHAN];
    logic [15:0]           q_lat_d [NUM_CHAN];
    logic [DEPTH_LOG2-1:0] wr_ptr_q [NF];
    logic [DEPTH_LOG2-1:0] wr_ptr_d [NF];
    logic [DEPTH_LOG2-1:0] rd_ptr_q [NF];
    logic [DEPTH_LOG2-1:0] rd_ptr_d [NF];
    logic [DEPTH_LOG2-1:0] count_q  [NF];
    logic [DEPTH_LOG2-1:0] count_d  [NF];
    logic [15:0]           chan_fifodata_q, chan_fifodata_d;
    logic [NUM_CHAN:0]     chan_empty_q, chan_empty_d;
    logic [9:0]            chan_usedw_q, chan_usedw_d;
    logic [NUM_CHAN:0]     overrun_q, overrun_d;

    logic [NF-1:0]         wr_en;
    logic [NF-1:0]         pop;
    logic [NF-1:0]         ovr_set;
    logic [15:0]           wr_data [NF];

    // Write sources: control port and the two-cycle I/Q sequencer
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        wr_en   = '0;
        ovr_set = '0;
        for (int unsigned k = 0; k < NUM_CHAN; k++) q_lat_d[k] = q_lat_q[k];
        for (int unsigned f = 0; f < NF; f++) wr_data[f] = '0;

        if (ctrl_wr) begin
            if (count_q[0] != CNT_FULL) begin
                wr_en[0]   = 1'b1;
                wr_data[0] = ctrl_data;
            end else begin
                ovr_set[0] = 1'b1;
            end
        end

        case (state_q)
            STATE_IDLE: begin
                if (rxstrobe) begin
                    state_d = STATE_WR_Q;
                    for (int unsigned k = 0; k < NUM_CHAN; k++) begin
                        mask_d[k]  = 1'b0;
                        q_lat_d[k] = rx_data[32*k+16 +: 16];
                        if (32'(channels) > k) begin
                            // A flushed FIFO must not receive a lone Q next cycle
                            if (count_q[k+1] <= CNT_PAIR_MAX) begin
                                wr_en[k+1]   = 1'b1;
                                wr_data[k+1] = rx_data[32*k +: 16];
                                mask_d[k]    = ~flush[k+1];
                            end else begin
                                ovr_set[k+1] = 1'b1;
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = STATE_IDLE;
                for (int unsigned k = 0; k < NUM_CHAN; k++) begin
                    if (mask_q[k]) begin
                        wr_en[k+1]   = 1'b1;
                        wr_data[k+1] = q_lat_q[k];
                    end
                    if (rxstrobe && (32'(channels) > k)) ovr_set[k+1] = 1'b1;
                end
            end
        endcase
    end

    // Pointer/count update and registered read port
    always_comb begin
        chan_fifodata_d = '0;
        chan_usedw_d    = '0;
        chan_empty_d    = '0;
        overrun_d       = (overrun_q & ~overrun_clr) | ovr_set;
        for (int unsigned f = 0; f < NF; f++) begin
            pop[f] = chan_rdreq && (rd_select == 4'(f)) && (count_q[f] != '0);
            if (flush[f]) begin
                wr_ptr_d[f] = '0;
                rd_ptr_d[f] = '0;
                count_d[f]  = '0;
            end else begin
                wr_ptr_d[f] = wr_ptr_q[f] + DEPTH_LOG2'(wr_en[f]);
                rd_ptr_d[f] = rd_ptr_q[f] + DEPTH_LOG2'(pop[f]);
                count_d[f]  = count_q[f];
                if (wr_en[f] && !pop[f]) count_d[f] = count_q[f] + 1'b1;
                if (!wr_en[f] && pop[f]) count_d[f] = count_q[f] - 1'b1;
            end
            chan_empty_d[f] = (count_d[f] == '0);
            if (rd_select == 4'(f)) begin
                chan_usedw_d = 10'(count_d[f]);
                // Forward a word landing at the head so data is valid with empty=0
                if (wr_en[f] && !flush[f] && (wr_ptr_q[f] == rd_ptr_d[f]))
                    chan_fifodata_d = wr_data[f];
                else
                    chan_fifodata_d = mem_q[f][rd_ptr_d[f]];
            end
        end
    end

    always_ff @(posedge rxclk) begin
        for (int unsigned f = 0; f < NF; f++) begin
            if (wr_en[f] && !flush[f]) mem_q[f][wr_ptr_q[f]] <= wr_data[f];
        end
    end

    always_ff @(posedge rxclk) begin
        if (reset) begin
            state_q         <= STATE_IDLE;
            mask_q          <= '0;
            chan_fifodata_q <= '0;
            chan_empty_q    <= '1;
            chan_usedw_q    <= '0;
            overrun_q       <= '0;
            for (int unsigned k = 0; k < NUM_CHAN; k++) q_lat_q[k] <= '0;
            for (int unsigned f = 0; f < NF; f++) begin
                wr_ptr_q[f] <= '0;
                rd_ptr_q[f] <= '0;
                count_q[f]  <= '0;
            end
        end else begin
            state_q         <= state_d;
            mask_q          <= mask_d;
            chan_fifodata_q <= chan_fifodata_d;
            chan_empty_q    <= chan_empty_d;
            chan_usedw_q    <= chan_usedw_d;
            overrun_q       <= overrun_d;
            for (int unsigned k = 0; k < NUM_CHAN; k++) q_lat_q[k] <= q_lat_d[k];
            for (int unsigned f = 0; f < NF; f++) begin
                wr_ptr_q[f] <= wr_ptr_d[f];
                rd_ptr_q[f] <= rd_ptr_d[f];
                count_q[f]  <= count_d[f];
            end
        end
    end

    assign chan_fifodata = chan_fifodata_q;
    assign chan_empty    = chan_empty_q;
    assign chan_usedw    = chan_usedw_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_rx_chan_fifo_bank.sv
// Scoreboard bench for rx_chan_fifo_bank: per-FIFO expected-word queues are
// filled as stimulus is driven and drained against the show-ahead read port.
module tb_rx_chan_fifo_bank;

    localparam int NC = 2;
    localparam int NF = NC + 1;

    logic              rxclk = 1'b0;
    logic              reset = 1'b1;
    logic [3:0]        channels = '0;
    logic              rxstrobe = 1'b0;
    logic [32*NC-1:0]  rx_data = '0;
    logic              ctrl_wr = 1'b0;
    logic [15:0]       ctrl_data = '0;
    logic [NC:0]       flush = '0;
    logic [NC:0]       overrun_clr = '0;
    logic [3:0]        rd_select = '0;
    logic              chan_rdreq = 1'b0;
    logic [15:0]       chan_fifodata;
    logic [NC:0]       chan_empty;
    logic [9:0]        chan_usedw;
    logic [NC:0]       overrun;

    int                n_tests = 0;
    int                n_fail  = 0;
    logic [15:0]       exp_q [NF][$];
    logic [NC:0]       exp_ovr = '0;
    bit                busy = 1'b0;
    int                sn = 0;

    rx_chan_fifo_bank #(.NUM_CHAN(NC), .DEPTH_LOG2(10)) dut (
        .rxclk(rxclk), .reset(reset), .channels(channels), .rxstrobe(rxstrobe),
        .rx_data(rx_data), .ctrl_wr(ctrl_wr), .ctrl_data(ctrl_data), .flush(flush),
        .overrun_clr(overrun_clr), .rd_select(rd_select), .chan_rdreq(chan_rdreq),
        .chan_fifodata(chan_fifodata), .chan_empty(chan_empty),
        .chan_usedw(chan_usedw), .overrun(overrun)
    );

    always #5 rxclk = ~rxclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply the reference behaviour for the inputs currently driven, then clock.
    task automatic tick();
        bit [NF-1:0] acc;
        logic [NC:0] set;
        acc = '0;
        set = '0;
        if (reset) begin
            for (int f = 0; f < NF; f++) exp_q[f].delete();
            exp_ovr = '0;
            busy    = 1'b0;
        end else begin
            if (ctrl_wr) begin
                if (exp_q[0].size() < 1023) acc[0] = 1'b1;
                else set[0] = 1'b1;
            end
            if (rxstrobe) begin
                for (int k = 0; k < NC; k++) begin
                    if (k < int'(channels)) begin
                        if (!busy && exp_q[k+1].size() <= 1021) acc[k+1] = 1'b1;
                        else set[k+1] = 1'b1;
                    end
                end
            end
            for (int f = 0; f < NF; f++) begin
                if (chan_rdreq && !flush[f] && rd_select == 4'(f) && exp_q[f].size() > 0)
                    check_eq("pop_data", 32'(chan_fifodata), 32'(exp_q[f].pop_front()));
            end
            if (acc[0]) exp_q[0].push_back(ctrl_data);
            for (int k = 0; k < NC; k++) begin
                if (acc[k+1]) begin
                    exp_q[k+1].push_back(rx_data[32*k +: 16]);
                    exp_q[k+1].push_back(rx_data[32*k+16 +: 16]);
                end
            end
            for (int f = 0; f < NF; f++) if (flush[f]) exp_q[f].delete();
            exp_ovr = (exp_ovr & ~overrun_clr) | set;
            busy    = rxstrobe && !busy;
        end
        @(posedge rxclk);
        #1;
    endtask

    task automatic do_strobe();
        for (int k = 0; k < NC; k++) begin
            rx_data[32*k +: 16]    = 16'(32'h1000 + 32'h2000 * k + sn);
            rx_data[32*k+16 +: 16] = 16'(32'h2000 + 32'h2000 * k + sn);
        end
        sn++;
        rxstrobe = 1'b1;
        tick();
        rxstrobe = 1'b0;
    endtask

    task automatic check_usedw(input int sel, input string tag, input int exp);
        rd_select = 4'(sel);
        tick();
        tick();
        check_eq(tag, 32'(chan_usedw), 32'(exp));
    endtask

    task automatic flush_all();
        flush = '1;
        overrun_clr = '1;
        tick();
        flush = '0;
        overrun_clr = '0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check_eq("rst_empty", 32'(chan_empty), 32'h7);
        check_eq("rst_usedw", 32'(chan_usedw), 32'h0);
        check_eq("rst_data",  32'(chan_fifodata), 32'h0);
        check_eq("rst_ovr",   32'(overrun), 32'h0);
        tick();

        // Two channels, spaced strobes, ordered readback
        channels = 4'd2;
        sn = 0;
        repeat (3) begin
            do_strobe();
            repeat (3) tick();
        end
        check_usedw(1, "t1_usedw1", 6);
        check_usedw(2, "t1_usedw2", 6);
        check_eq("t1_head2", 32'(chan_fifodata), 32'h3000);
        rd_select = 4'd1;
        tick();
        tick();
        check_eq("t1_head1", 32'(chan_fifodata), 32'h1000);
        chan_rdreq = 1'b1;
        repeat (6) tick();
        chan_rdreq = 1'b0;
        tick();
        check_eq("t1_empty1", 32'(chan_empty[1]), 32'h1);
        check_eq("t1_model1", 32'(exp_q[1].size()), 32'h0);
        flush_all();

        // One channel enabled only
        channels = 4'd1;
        repeat (10) begin
            do_strobe();
            tick();
        end
        check_usedw(1, "t2_usedw1", 20);
        check_eq("t2_empty2", 32'(chan_empty[2]), 32'h1);
        check_eq("t2_ovr", 32'(overrun), 32'h0);

        // Fill to the pair boundary
        repeat (501) begin
            do_strobe();
            tick();
        end
        check_usedw(1, "t3_fill", 1022);
        do_strobe();
        tick();
        check_usedw(1, "t3_drop_usedw", 1022);
        check_eq("t3_drop_ovr", 32'(overrun), 32'h2);
        check_eq("t3_drop_model", 32'(overrun), 32'(exp_ovr));
        chan_rdreq = 1'b1;
        tick();
        chan_rdreq = 1'b0;
        tick();
        do_strobe();
        tick();
        check_usedw(1, "t3_accept_free2", 1023);
        do_strobe();
        tick();
        check_usedw(1, "t3_full_drop", 1023);
        check_eq("t3_full_ovr", 32'(overrun), 32'(exp_ovr));
        flush_all();
        check_eq("t3_flush_empty", 32'(chan_empty), 32'h7);

        // Back-to-back strobes
        channels = 4'd2;
        rxstrobe = 1'b1;
        sn = 16'h50;
        do_strobe();
        do_strobe();
        rxstrobe = 1'b0;
        tick();
        check_eq("t4_ovr", 32'(overrun), 32'h6);
        check_usedw(1, "t4_usedw1", 2);
        check_usedw(2, "t4_usedw2", 2);
        rd_select = 4'd1;
        tick();
        check_eq("t4_head1", 32'(chan_fifodata), 32'h1050);
        chan_rdreq = 1'b1;
        repeat (2) tick();
        chan_rdreq = 1'b0;
        overrun_clr = 3'b110;
        tick();
        overrun_clr = '0;
        check_eq("t4_ovr_clr", 32'(overrun), 32'h0);
        flush_all();

        // Streaming with concurrent pops across pointer wrap
        channels = 4'd1;
        rd_select = 4'd1;
        sn = 0;
        repeat (2) begin
            do_strobe();
            tick();
        end
        tick();
        chan_rdreq = 1'b1;
        repeat (1500) begin
            do_strobe();
            tick();
            check_eq("t5_usedw", 32'(chan_usedw), 32'(exp_q[1].size()));
        end
        repeat (8) tick();
        chan_rdreq = 1'b0;
        tick();
        check_eq("t5_empty", 32'(chan_empty[1]), 32'h1);
        check_eq("t5_model", 32'(exp_q[1].size()), 32'h0);
        check_eq("t5_ovr", 32'(overrun), 32'h0);

        // Control FIFO overflow, flush vs pop, invalid select
        rd_select = 4'd0;
        ctrl_wr = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            ctrl_data = 16'(i + 16'h0a00);
            tick();
        end
        ctrl_wr = 1'b0;
        check_usedw(0, "t6_usedw", 1023);
        check_eq("t6_ovr0", 32'(overrun), 32'h1);
        check_eq("t6_head0", 32'(chan_fifodata), 32'h0a00);
        chan_rdreq = 1'b1;
        repeat (3) tick();
        flush[0] = 1'b1;
        tick();
        flush[0] = 1'b0;
        chan_rdreq = 1'b0;
        tick();
        check_eq("t6_flush_usedw", 32'(chan_usedw), 32'h0);
        check_eq("t6_flush_empty", 32'(chan_empty[0]), 32'h1);
        check_eq("t6_flush_ovr", 32'(overrun), 32'h1);
        rd_select = 4'd3;
        tick();
        chan_rdreq = 1'b1;
        tick();
        chan_rdreq = 1'b0;
        tick();
        check_eq("t6_sel3_usedw", 32'(chan_usedw), 32'h0);
        check_eq("t6_sel3_data", 32'(chan_fifodata), 32'h0);
        check_eq("t6_sel3_empty", 32'(chan_empty), 32'h7);
        check_eq("t6_sel3_ovr", 32'(overrun), 32'(exp_ovr));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
